// File: rtl/processing_element16.sv
// rtl/processing_element16.sv - binary16 multiply-accumulate element, optional PE16_SATURATE_EN saturation
module processing_element16 #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] floatA,
    input  logic [DATA_WIDTH-1:0] floatB,
    output logic [DATA_WIDTH-1:0] result
);

    localparam logic [15:0] QNAN = 16'h7E00;

    logic [15:0] acc;
    logic [15:0] product;
    logic [15:0] acc_next;

    // Finite overflow: signed infinity, or signed max finite when saturating.
    function automatic logic [15:0] overflow_value(input logic sign);
`ifdef PE16_SATURATE_EN
        return {sign, 15'h7BFF};
`else
        return {sign, 15'h7C00};
`endif
    endfunction

    // Round-to-nearest-even on a normalised mantissa, then flush/overflow by final exponent.
    function automatic logic [15:0] round_pack(input logic              sign,
                                               input logic signed [7:0] exp_in,
                                               input logic [9:0]        man,
                                               input logic              guard,
                                               input logic              sticky);
        logic              round_up;
        logic [10:0]       man_r;
        logic signed [7:0] e;
        round_up = guard & (sticky | man[0]);
        man_r    = {1'b0, man} + {10'd0, round_up};
        e        = exp_in;
        if (man_r[10]) begin
            // Mantissa rolled over to 2.0; bits [9:0] are already zero.
            e = e + 8'sd1;
        end
        if (e <= 8'sd0) begin
            return {sign, 15'h0000};
        end else if (e >= 8'sd31) begin
            return overflow_value(sign);
        end else begin
            return {sign, e[4:0], man_r[9:0]};
        end
    endfunction

    // Product rounded to binary16; subnormal operands count as signed zero.
    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic              sp;
        logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        logic [21:0]       prod;
        logic signed [7:0] e;
        sp     = a[15] ^ b[15];
        a_zero = (a[14:10] == 5'd0);
        b_zero = (b[14:10] == 5'd0);
        a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
        b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
        a_nan  = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
        b_nan  = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            return QNAN;
        end
        if (a_inf || b_inf) begin
            return {sp, 15'h7C00};
        end
        if (a_zero || b_zero) begin
            return {sp, 15'h0000};
        end
        prod = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
        e    = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
        // Significand product lies in [1,4); renormalise when it reached 2.
        if (prod[21]) begin
            return round_pack(sp, e + 8'sd1, prod[20:11], prod[10], |prod[9:0]);
        end else begin
            return round_pack(sp, e, prod[19:10], prod[9], |prod[8:0]);
        end
    endfunction

    // Sum rounded to binary16 using guard/round/sticky alignment.
    function automatic logic [15:0] fp16_add(input logic [15:0] x, input logic [15:0] y);
        logic              x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
        logic              bs, ss;
        logic [4:0]        be, se, d;
        logic [9:0]        bm, sm;
        logic [14:0]       big;
        logic [13:0]       small_sig, shifted;
        logic              st;
        logic [14:0]       r;
        logic [3:0]        lz;
        logic [12:0]       n;
        logic signed [7:0] e;
        x_zero = (x[14:10] == 5'd0);
        y_zero = (y[14:10] == 5'd0);
        x_inf  = (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
        y_inf  = (y[14:10] == 5'h1F) && (y[9:0] == 10'd0);
        x_nan  = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
        y_nan  = (y[14:10] == 5'h1F) && (y[9:0] != 10'd0);
        if (x_nan || y_nan || (x_inf && y_inf && (x[15] != y[15]))) begin
            return QNAN;
        end
        if (x_inf) begin
            return {x[15], 15'h7C00};
        end
        if (y_inf) begin
            return {y[15], 15'h7C00};
        end
        if (x_zero && y_zero) begin
            return {x[15] & y[15], 15'h0000};
        end
        if (x_zero) begin
            return y;
        end
        if (y_zero) begin
            return x;
        end
        // Larger magnitude goes first so the subtraction never goes negative.
        if (y[14:0] > x[14:0]) begin
            bs = y[15]; be = y[14:10]; bm = y[9:0];
            ss = x[15]; se = x[14:10]; sm = x[9:0];
        end else begin
            bs = x[15]; be = x[14:10]; bm = x[9:0];
            ss = y[15]; se = y[14:10]; sm = y[9:0];
        end
        d         = be - se;
        big       = {2'b01, bm, 3'b000};
        small_sig = {1'b1, sm, 3'b000};
        if (d >= 5'd14) begin
            shifted = 14'd0;
            st      = 1'b1;
        end else begin
            shifted = small_sig >> d;
            st      = |(small_sig & ~(14'h3FFF << d));
        end
        shifted[0] = shifted[0] | st;
        if (bs == ss) begin
            r = big + {1'b0, shifted};
        end else begin
            r = big - {1'b0, shifted};
        end
        if (r == 15'd0) begin
            return 16'h0000;
        end
        e = $signed({3'b000, be});
        if (r[14]) begin
            n = {r[13:2], r[1] | r[0]};
            e = e + 8'sd1;
        end else begin
            lz = 4'd0;
            for (int i = 0; i < 14; i++) begin
                if (r[i]) begin
                    lz = 4'(13 - i);
                end
            end
            // The leading one is shifted out of the 13-bit window as the hidden bit.
            n = r[12:0] << lz;
            e = e - $signed({4'b0000, lz});
        end
        return round_pack(bs, e, n[12:3], n[2], n[1] | n[0]);
    endfunction

    assign product  = fp16_mul(floatA[15:0], floatB[15:0]);
    assign acc_next = fp16_add(acc, product);
    assign result   = acc;

    // Accumulate one rounded product per edge; reset discards the partial sum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= 16'h0000;
        end else begin
            acc <= acc_next;
        end
    end

endmodule

// File: tb/tb_processing_element16.sv
// tb/tb_processing_element16.sv - directed bench for processing_element16
module tb_processing_element16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] floatA = 16'h0000;
    logic [15:0] floatB = 16'h0000;
    logic [15:0] result;

    int vectors = 0;
    int miscompares = 0;

`ifdef PE16_SATURATE_EN
    localparam logic [15:0] OVF_EXP = 16'h7BFF;
`else
    localparam logic [15:0] OVF_EXP = 16'h7C00;
`endif

    processing_element16 #(.DATA_WIDTH(16)) dut (
        .clk    (clk),
        .reset  (reset),
        .floatA (floatA),
        .floatB (floatB),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] expected);
        vectors++;
        assert (result === expected) else begin
            miscompares++;
            $error("FAIL %s: result=%h expected=%h", tag, result, expected);
        end
    endtask

    task automatic step(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] expected, input string tag);
        floatA = a;
        floatB = b;
        @(posedge clk);
        #1;
        check(tag, expected);
    endtask

    task automatic pulse_reset();
        floatA = 16'h0000;
        floatB = 16'h0000;
        reset  = 1'b0;
        #2;
        reset  = 1'b1;
    endtask

    initial begin
        #1 reset = 1'b0;
        #3 check("reset_low", 16'h0000);
        @(posedge clk);
        #1 check("reset_held", 16'h0000);
        #2 reset = 1'b1;

        step(16'h4000, 16'h4200, 16'h4600, "first_mac_2x3");
        step(16'h3C00, 16'h3800, 16'h4680, "acc_plus_half");
        for (int i = 0; i < 5; i++) begin
            step(16'h0000, 16'h0000, 16'h4680, "zero_padding");
        end

        #2 reset = 1'b0;
        #1 check("async_reset_midrun", 16'h0000);
        #1 reset = 1'b1;
        step(16'h4000, 16'h4200, 16'h4600, "after_release");
        step(16'hC000, 16'h4200, 16'h0000, "cancellation");

        pulse_reset();
        step(16'h3C01, 16'h3C01, 16'h3C02, "product_rounding");

        pulse_reset();
        step(16'hBC00, 16'h4000, 16'hC000, "neg_product");
        step(16'h3C00, 16'h3C00, 16'hBC00, "sub_normalise");

        pulse_reset();
        step(16'h6800, 16'h3C00, 16'h6800, "load_2048");
        step(16'h3C00, 16'h3C00, 16'h6800, "tie_to_even_down");
        step(16'h4200, 16'h3C00, 16'h6802, "tie_to_even_up");

        pulse_reset();
        step(16'h0400, 16'h3800, 16'h0000, "flush_to_zero");
        step(16'h0001, 16'h3C00, 16'h0000, "subnormal_input");

        pulse_reset();
        step(16'h7BFF, 16'h4000, OVF_EXP, "overflow");

        pulse_reset();
        step(16'h7E00, 16'h3C00, 16'h7E00, "nan_operand");
        step(16'h0000, 16'h0000, 16'h7E00, "nan_sticky_1");
        step(16'h4000, 16'h4200, 16'h7E00, "nan_sticky_2");

        pulse_reset();
        step(16'h0000, 16'h7C00, 16'h7E00, "zero_times_inf");

        pulse_reset();
        step(16'h7C00, 16'h3C00, 16'h7C00, "inf_operand");
        step(16'h4000, 16'h4000, 16'h7C00, "inf_sticky");
        step(16'hFC00, 16'h3C00, 16'h7E00, "inf_minus_inf");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
